muldiv_unit: RTL

Iterative multiply/divide unit implementing the RV32M operations for a parametrised data width. It sits beside the datapath ALU: it takes the same SrcA/SrcB operands, runs a multi-cycle shift-add or restoring-divide sequence, and returns a registered result. That result feeds the result mux while the control unit stalls the core on `busy`.

---
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (shift-add / restoring divide)
// Optional MULDIV_FAST_MUL_EN: single-cycle array multiplier for MUL/MULH/MULHSU/MULHU.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_nx;
  logic [2:0]      op_q;
  logic [XLEN-1:0] acc_hi, acc_lo, opb;
  logic            neg_q, neg_r;
  logic [CW-1:0]   cnt;

  logic            accept, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, ovf, special, fast_mul;
  logic [XLEN-1:0] special_res, fast_res;

  logic [XLEN:0]   sum, trial;
  logic            ge;
  logic [XLEN-1:0] hi_nx, lo_nx;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] q_s, r_s, final_res;

  assign accept   = start && (state != CALC);
  assign a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign sa       = a_signed && SrcA[XLEN-1];
  assign sb       = b_signed && SrcB[XLEN-1];
  assign mag_a    = sa ? -SrcA : SrcA;
  assign mag_b    = sb ? -SrcB : SrcB;

  assign div_zero = op[2] && (SrcB == '0);
  assign ovf      = ((op == 3'b100) || (op == 3'b110)) && (SrcA == MOST_NEG) && (SrcB == '1);
  assign special  = div_zero || ovf;
  always_comb begin
    special_res = '0;
    if (div_zero) special_res = op[1] ? SrcA : '1;
    else          special_res = op[1] ? '0 : SrcA;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fa, fb;
  logic signed [2*XLEN-1:0] fp;
  assign fa       = {a_signed && SrcA[XLEN-1], SrcA};
  assign fb       = {b_signed && SrcB[XLEN-1], SrcB};
  assign fp       = fa * fb;
  assign fast_mul = !op[2];
  assign fast_res = (op[1:0] == 2'b00) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
`else
  assign fast_mul = 1'b0;
  assign fast_res = '0;
`endif

  // Multiply: acc_lo holds the multiplier, shifted out LSB-first as the product fills in.
  // Divide: acc_hi is the partial remainder, acc_lo shifts the dividend out and quotient in.
  assign sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign trial = {acc_hi, acc_lo[XLEN-1]} - {1'b0, opb};
  assign ge    = !trial[XLEN];

  always_comb begin
    hi_nx = {sum[XLEN:1]};
    lo_nx = {sum[0], acc_lo[XLEN-1:1]};
    if (op_q[2]) begin
      hi_nx = ge ? trial[XLEN-1:0] : {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
      lo_nx = {acc_lo[XLEN-2:0], ge};
    end
  end

  assign prod_s = neg_q ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
  assign q_s    = neg_q ? -lo_nx : lo_nx;
  assign r_s    = neg_r ? -hi_nx : hi_nx;

  always_comb begin
    final_res = '0;
    case (op_q)
      3'b000:                 final_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = q_s;
      default:                final_res = r_s;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nx = (special || fast_mul) ? DONE : CALC;
        else        state_nx = IDLE;
      end
      CALC:    state_nx = (cnt == LAST) ? DONE : CALC;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op_q   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      Result <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q   <= op;
        neg_q  <= sa ^ sb;
        neg_r  <= sa;
        cnt    <= '0;
        acc_hi <= '0;
        acc_lo <= op[2] ? mag_a : mag_b;
        opb    <= op[2] ? mag_b : mag_a;
        if (special)       Result <= special_res;
        else if (fast_mul) Result <= fast_res;
      end else if (state == CALC) begin
        acc_hi <= hi_nx;
        acc_lo <= lo_nx;
        cnt    <= cnt + 1'b1;
        if (cnt == LAST) Result <= final_res;
      end
    end
  end

endmodule
